// File: rtl/hazard_control_pkg.sv
// Shared mips32 pipeline definitions: multiply/divide tracker states, register constants, default latencies.
// No logic; latency and backpressure are defined by the modules that import it.
package mips_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEF_MULT_LATENCY = 4;
  localparam int DEF_DIV_LATENCY  = 32;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_control_md_busy_tracker.sv
// Multiply/divide occupancy tracker: one accepted start keeps the unit busy for the op's latency.
// Latency: busy from the cycle after acceptance for L cycles; done marks the last one. Starts while busy are ignored.
module md_busy_tracker
  import mips_pkg::*;
#(
  parameter int MULT_LATENCY = DEF_MULT_LATENCY,
  parameter int DIV_LATENCY  = DEF_DIV_LATENCY
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic isDiv,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(maxOf(MULT_LATENCY, DIV_LATENCY) + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_LATENCY);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_LATENCY);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state <= MD_BUSY;
            cnt   <= isDiv ? CNT_DIV : CNT_MULT;
          end
        end
        MD_BUSY: begin
          // cnt counts the busy cycles still to go, including the current one
          if (cnt == CNT_ONE) begin
            state <= MD_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= MD_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == MD_BUSY);
  assign done = (state == MD_BUSY) && (cnt == CNT_ONE);

endmodule

// File: rtl/hazard_control.sv
// Stall/flush controller for the mips32 pipeline: load-use and HI/LO hazards, wrong-path squash on taken branch.
// Latency: pipeline controls are combinational from inputs and tracker state; stalling holds PC/IF/ID and bubbles ID/EX.
module hazard_control
  import mips_pkg::*;
#(
  parameter int MULT_LATENCY = DEF_MULT_LATENCY,
  parameter int DIV_LATENCY  = DEF_DIV_LATENCY
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] rsID,
  input  logic [4:0] rtID,
  input  logic       useRsID,
  input  logic       useRtID,
  input  logic       hiloReadID,
  input  logic       mdStartID,
  input  logic       isDivID,
  input  logic [4:0] destRegEX,
  input  logic       memReadEX,
  input  logic       branchTakenEX,
  output logic       stallPC,
  output logic       stallIFID,
  output logic       bubbleIDEX,
  output logic       flushIFID,
  output logic       mdBusy,
  output logic       mdDone
);

  logic rsMatch;
  logic rtMatch;
  logic loadUse;
  logic mdHazard;
  logic stall;
  logic mdAccept;

  assign rsMatch  = useRsID && (rsID == destRegEX);
  assign rtMatch  = useRtID && (rtID == destRegEX);
  assign loadUse  = memReadEX && (destRegEX != REG_ZERO) && (rsMatch || rtMatch);

  // A new mult/div while busy is a structural conflict, so it waits like mfhi/mflo
  assign mdHazard = mdBusy && (hiloReadID || mdStartID);
  assign stall    = loadUse || mdHazard;

  // Squashed or stalled starts never reach the unit
  assign mdAccept = mdStartID && !branchTakenEX && !stall;

  md_busy_tracker #(
    .MULT_LATENCY(MULT_LATENCY),
    .DIV_LATENCY (DIV_LATENCY)
  ) u_md_busy_tracker (
    .clock(clock),
    .reset(reset),
    .start(mdAccept),
    .isDiv(isDivID),
    .busy (mdBusy),
    .done (mdDone)
  );

  always_comb begin
    stallPC    = 1'b0;
    stallIFID  = 1'b0;
    bubbleIDEX = 1'b0;
    flushIFID  = 1'b0;
    if (!reset) begin
      if (branchTakenEX) begin
        flushIFID  = 1'b1;
        bubbleIDEX = 1'b1;
      end else if (stall) begin
        stallPC    = 1'b1;
        stallIFID  = 1'b1;
        bubbleIDEX = 1'b1;
      end
    end
  end

endmodule
